// File: rtl/frame_buf_pkg.sv
// frame_buf_pkg: shared constants, bank index type and writer states for the frame-buffer scheduler
package frame_buf_pkg;
  localparam int FRAME_WORDS = 307200;
  localparam int ADDR_W = 20;
  localparam int NUM_BANKS = 3;
  typedef logic [1:0] bank_t;
  typedef enum logic {W_IDLE, W_ACTIVE} wstate_t;
  localparam logic [ADDR_W-1:0] BANK0_BASE = '0;
  localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BANK2_BASE = ADDR_W'(2 * FRAME_WORDS);
endpackage

// File: rtl/frame_bank_sched_if.sv
// frame_bank_sched_if: writer/VGA event pulses in, bank assignments and drop count out
interface frame_bank_sched_if #(
  parameter int ADDR_W = 20,
  parameter int DROP_W = 16
);
  logic i_wr_sof;
  logic i_wr_eof;
  logic i_rd_eof;
  logic o_wr_grant;
  frame_buf_pkg::bank_t o_wr_bank;
  logic [ADDR_W-1:0] o_wr_base;
  frame_buf_pkg::bank_t o_rd_bank;
  logic [ADDR_W-1:0] o_rd_base;
  logic o_rd_valid;
  logic [DROP_W-1:0] o_drop_cnt;
  modport master (
    output i_wr_sof, i_wr_eof, i_rd_eof,
    input o_wr_grant, o_wr_bank, o_wr_base, o_rd_bank, o_rd_base, o_rd_valid, o_drop_cnt
  );
  modport slave (
    input i_wr_sof, i_wr_eof, i_rd_eof,
    output o_wr_grant, o_wr_bank, o_wr_base, o_rd_bank, o_rd_base, o_rd_valid, o_drop_cnt
  );
endinterface

// File: rtl/bank_alloc.sv
// bank_alloc: lowest bank index not held by busy_a nor by busy_b when busy_b_valid
module bank_alloc
  import frame_buf_pkg::*;
(
  input  bank_t busy_a,
  input  bank_t busy_b,
  input  logic  busy_b_valid,
  output bank_t free_bank
);
  logic used0, used1;
  always_comb begin
    used0 = busy_a == 2'd0 || (busy_b_valid && busy_b == 2'd0);
    used1 = busy_a == 2'd1 || (busy_b_valid && busy_b == 2'd1);
    free_bank = !used0 ? 2'd0 : !used1 ? 2'd1 : 2'd2;
  end
endmodule

// File: rtl/frame_bank_sched.sv
// frame_bank_sched: tear-free triple-buffer bank scheduler between frame writer and VGA reader
module frame_bank_sched #(
  parameter int FRAME_WORDS = frame_buf_pkg::FRAME_WORDS,
  parameter int ADDR_W = frame_buf_pkg::ADDR_W,
  parameter int DROP_W = 16
) (
  input logic i_clk25m,
  input logic i_rst_clk25m,
  frame_bank_sched_if.slave bus
);
  import frame_buf_pkg::*;
  localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(FRAME_WORDS);
  localparam logic [ADDR_W-1:0] BASE2 = ADDR_W'(2 * FRAME_WORDS);
  wstate_t state_q, state_d;
  bank_t wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, ready_bank_q, ready_bank_d, alloc_bank;
  logic rd_valid_q, rd_valid_d, ready_valid_q, ready_valid_d, eof_now;
  logic [DROP_W-1:0] drop_q, drop_d;
  bank_alloc u_alloc (
    .busy_a(rd_bank_d),
    .busy_b(ready_bank_d),
    .busy_b_valid(ready_valid_d),
    .free_bank(alloc_bank)
  );
  always_ff @(posedge i_clk25m) begin
    if (i_rst_clk25m) begin
      state_q <= W_IDLE;
      wr_bank_q <= 2'd0;
      rd_bank_q <= 2'd0;
      rd_valid_q <= 1'b0;
      ready_bank_q <= 2'd0;
      ready_valid_q <= 1'b0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_valid_q <= rd_valid_d;
      ready_bank_q <= ready_bank_d;
      ready_valid_q <= ready_valid_d;
      drop_q <= drop_d;
    end
  end
  always_comb begin
    eof_now = state_q == W_ACTIVE && bus.i_wr_eof;
    ready_bank_d = eof_now ? wr_bank_q : ready_bank_q;
    ready_valid_d = eof_now | ready_valid_q;
    drop_d = (eof_now && ready_valid_q && !bus.i_rd_eof && !(&drop_q)) ? drop_q + 1'b1 : drop_q;
    rd_bank_d = rd_bank_q;
    rd_valid_d = rd_valid_q;
    if (bus.i_rd_eof && ready_valid_d) begin
      rd_bank_d = ready_bank_d;
      rd_valid_d = 1'b1;
      ready_valid_d = 1'b0;
    end
  end
  always_comb begin
    state_d = bus.i_wr_sof ? W_ACTIVE : eof_now ? W_IDLE : state_q;
    wr_bank_d = (bus.i_wr_sof && (state_q == W_IDLE || eof_now)) ? alloc_bank : wr_bank_q;
  end
  always_comb begin
    bus.o_wr_grant = state_q == W_ACTIVE;
    bus.o_wr_bank = wr_bank_q;
    bus.o_wr_base = wr_bank_q == 2'd1 ? BASE1 : wr_bank_q == 2'd2 ? BASE2 : '0;
    bus.o_rd_bank = rd_bank_q;
    bus.o_rd_base = rd_bank_q == 2'd1 ? BASE1 : rd_bank_q == 2'd2 ? BASE2 : '0;
    bus.o_rd_valid = rd_valid_q;
    bus.o_drop_cnt = drop_q;
  end
endmodule

// File: tb/tb_frame_bank_sched.sv
// tb_frame_bank_sched: directed scoreboard bench for the triple-buffer scheduler
module tb_frame_bank_sched;
  typedef struct packed {
    logic g;
    logic [1:0] wb;
    logic [1:0] rb;
    logic v;
    logic [2:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];
  string tags[$];
  frame_bank_sched_if #(.ADDR_W(20), .DROP_W(3)) bus ();
  frame_bank_sched #(.FRAME_WORDS(307200), .ADDR_W(20), .DROP_W(3)) dut (
    .i_clk25m(clk),
    .i_rst_clk25m(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic g, input int wb, input int rb, input logic v, input int d);
    mk.g = g;
    mk.wb = 2'(wb);
    mk.rb = 2'(rb);
    mk.v = v;
    mk.d = 3'(d);
  endfunction
  function automatic logic [19:0] base(input logic [1:0] b);
    return 20'(b) * 20'd307200;
  endfunction
  task automatic step(input string tag, input logic r, input logic s, input logic e, input logic q, input exp_t x);
    exp_t want, got;
    string t;
    @(negedge clk);
    rst = r;
    bus.i_wr_sof = s;
    bus.i_wr_eof = e;
    bus.i_rd_eof = q;
    sb.push_back(x);
    tags.push_back(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_wr_sof = 1'b0;
    bus.i_wr_eof = 1'b0;
    bus.i_rd_eof = 1'b0;
    want = sb.pop_front();
    t = tags.pop_front();
    got = {bus.o_wr_grant, bus.o_wr_bank, bus.o_rd_bank, bus.o_rd_valid, bus.o_drop_cnt};
    n_cmp++;
    assert (got === want && bus.o_wr_base === base(want.wb) && bus.o_rd_base === base(want.rb)) else begin
      n_bad++;
      $error("FAIL %s: got g=%0d wb=%0d wbase=%0d rb=%0d rbase=%0d v=%0d drop=%0d, expected g=%0d wb=%0d wbase=%0d rb=%0d rbase=%0d v=%0d drop=%0d",
             t, got.g, got.wb, bus.o_wr_base, got.rb, bus.o_rd_base, got.v, got.d,
             want.g, want.wb, base(want.wb), want.rb, base(want.rb), want.v, want.d);
    end
  endtask
  initial begin
    int dprev;
    bus.i_wr_sof = 1'b0;
    bus.i_wr_eof = 1'b0;
    bus.i_rd_eof = 1'b0;
    step("reset", 1, 0, 0, 0, mk(0, 0, 0, 0, 0));
    step("first_sof", 0, 1, 0, 0, mk(1, 1, 0, 0, 0));
    step("first_eof", 0, 0, 1, 0, mk(0, 1, 0, 0, 0));
    step("first_swap", 0, 0, 0, 1, mk(0, 1, 1, 1, 0));
    step("sof_bank0", 0, 1, 0, 0, mk(1, 0, 1, 1, 0));
    step("eof_ready0", 0, 0, 1, 0, mk(0, 0, 1, 1, 0));
    step("sof_bank2", 0, 1, 0, 0, mk(1, 2, 1, 1, 0));
    step("eof_drop", 0, 0, 1, 0, mk(0, 2, 1, 1, 1));
    step("swap_to2", 0, 0, 0, 1, mk(0, 2, 2, 1, 1));
    step("sof_bank0b", 0, 1, 0, 0, mk(1, 0, 2, 1, 1));
    step("eof_rd_same0", 0, 0, 1, 1, mk(0, 0, 0, 1, 1));
    step("rd_repeat0", 0, 0, 0, 1, mk(0, 0, 0, 1, 1));
    step("sof_bank1", 0, 1, 0, 0, mk(1, 1, 0, 1, 1));
    step("eof_rd_same1", 0, 0, 1, 1, mk(0, 1, 1, 1, 1));
    step("rd_repeat1", 0, 0, 0, 1, mk(0, 1, 1, 1, 1));
    step("abort_sof", 0, 1, 0, 0, mk(1, 0, 1, 1, 1));
    step("abort_again", 0, 1, 0, 0, mk(1, 0, 1, 1, 1));
    step("abort_eof", 0, 0, 1, 0, mk(0, 0, 1, 1, 1));
    step("abort_swap", 0, 0, 0, 1, mk(0, 0, 0, 1, 1));
    step("abort_once", 0, 0, 0, 1, mk(0, 0, 0, 1, 1));
    step("sof_b1", 0, 1, 0, 0, mk(1, 1, 0, 1, 1));
    step("sof_eof_active", 0, 1, 1, 0, mk(1, 2, 0, 1, 1));
    step("eof_drop2", 0, 0, 1, 0, mk(0, 2, 0, 1, 2));
    step("idle_eof_ign", 0, 0, 1, 0, mk(0, 2, 0, 1, 2));
    step("idle_sof_eof", 0, 1, 1, 0, mk(1, 1, 0, 1, 2));
    step("rd_during_wr", 0, 0, 0, 1, mk(1, 1, 2, 1, 2));
    step("mid_reset", 1, 0, 0, 0, mk(0, 0, 0, 0, 0));
    step("late_eof", 0, 0, 1, 0, mk(0, 0, 0, 0, 0));
    dprev = 0;
    for (int i = 0; i < 10; i++) begin
      step("sat_sof", 0, 1, 0, 0, mk(1, (i % 2 == 0) ? 1 : 2, 0, 0, dprev));
      dprev = (i > 7) ? 7 : i;
      step("sat_eof", 0, 0, 1, 0, mk(0, (i % 2 == 0) ? 1 : 2, 0, 0, dprev));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
